// File: rtl/dmem_mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_if
// Description : Data-memory bus between the single-cycle core and dmem_mmio,
//               bundled with the transmit-FIFO valid/ready drain port.
//               master : core side plus byte consumer
//                        (drives we/a/wd/tx_ready)
//               slave  : dmem_mmio responder
//                        (drives rd/tx_data/tx_valid)
// Signals     : we       write strobe (core memwrite)
//               a        byte address (core aluout)
//               wd       write data (core writedata)
//               rd       read data (core readdata), combinational from a
//               tx_data  transmit FIFO head byte
//               tx_valid transmit FIFO non-empty
//               tx_ready consumer accepts the head byte this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_mmio_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output we,
        output a,
        output wd,
        output tx_ready,
        input  rd,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  we,
        input  a,
        input  wd,
        input  tx_ready,
        output rd,
        output tx_data,
        output tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio
// Description : Responder end of the core's data-memory bus. Holds a
//               word-addressed data RAM and a 256-byte MMIO window with a
//               transmit byte FIFO (TXDATA), a STATUS register and a
//               free-running cycle counter (CYCLE). All reads are
//               combinational; all writes commit on the rising clock edge.
// Ports       : clk    rising-edge clock
//               reset  synchronous, active-high reset
//               bus    dmem_mmio_if.slave (we/a/wd/rd, tx_data/tx_valid/tx_ready)
// MMIO map    : +0x00 TXDATA  write pushes wd[7:0], reads 0
//               +0x04 STATUS  {count, ovf, full, empty}; write wd[2]=1 clears ovf
//               +0x08 CYCLE   read counter, write loads it
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio #(
    parameter int          RAM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  wire          clk,
    input  wire          reset,
    dmem_mmio_if.slave   bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_ram_aw = $clog2(RAM_WORDS);   // RAM index width
    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);  // FIFO pointer width
    localparam int c_cnt_w  = c_ptr_w + 1;         // FIFO occupancy width

    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    // Word offsets inside the MMIO window (a[7:2]).
    localparam logic [5:0] c_off_txdata = 6'h00;
    localparam logic [5:0] c_off_status = 6'h01;
    localparam logic [5:0] c_off_cycle  = 6'h02;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]        r_mem [RAM_WORDS];
    logic [7:0]         r_buf [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_ovf;
    logic [31:0]        r_cycle;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                w_mmio_hit;
    logic [c_ram_aw-1:0] w_idx;
    logic [5:0]          w_off;
    logic                w_unused_addr;

    assign w_mmio_hit = (bus.a[31:8] == MMIO_BASE[31:8]);
    // Upper address bits above the RAM index are ignored, so the RAM
    // aliases throughout the non-MMIO address space.
    assign w_idx      = bus.a[c_ram_aw+1:2];
    assign w_off      = bus.a[7:2];
    // Byte-lane bits play no part in any decode.
    assign w_unused_addr = ^bus.a[1:0];

    logic w_wr_txdata;
    logic w_wr_status;
    logic w_wr_cycle;
    logic w_wr_ram;

    assign w_wr_ram    = bus.we && !w_mmio_hit;
    assign w_wr_txdata = bus.we && w_mmio_hit && (w_off == c_off_txdata);
    assign w_wr_status = bus.we && w_mmio_hit && (w_off == c_off_status);
    assign w_wr_cycle  = bus.we && w_mmio_hit && (w_off == c_off_cycle);

    // ------------------------------------------------------------------
    // Data RAM: combinational read, write on the edge, never reset.
    // A read of the word being written sees the old contents until the
    // edge has passed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_mem[w_idx] <= bus.wd;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    // Pop only exists while non-empty, so an empty FIFO never falls
    // through: a byte pushed into it is first visible on the next cycle.
    assign w_pop   = !w_empty && bus.tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same
    // cycle, because the slot is freed at the same edge.
    assign w_push  = w_wr_txdata && (!w_full || w_pop);
    assign w_drop  = w_wr_txdata && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_buf[r_wr_ptr] <= bus.wd[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a dropped push in the same cycle as a clear
    // cannot happen since the two writes use different offsets.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_wr_status && bus.wd[2]) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = r_buf[r_rd_ptr];

    // ------------------------------------------------------------------
    // Cycle counter: a load takes the place of that cycle's increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
        end else if (w_wr_cycle) begin
            r_cycle <= bus.wd;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] w_status;

    always_comb begin
        w_status                 = '0;
        w_status[c_ptr_w+3:3]    = r_count;
        w_status[2]              = r_ovf;
        w_status[1]              = w_full;
        w_status[0]              = w_empty;
    end

    always_comb begin
        bus.rd = '0;
        if (w_mmio_hit) begin
            case (w_off)
                c_off_status: bus.rd = w_status;
                c_off_cycle:  bus.rd = r_cycle;
                default:      bus.rd = '0;
            endcase
        end else begin
            bus.rd = r_mem[w_idx];
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Responder end of the core's data-memory bus: serves the processor's `memwrite` / `aluout` / `writedata` requests and returns `readdata`.
- Contains a word-addressed data RAM plus a small memory-mapped I/O region:
  - a byte transmit FIFO drained by an external valid/ready consumer;
  - a status register;
  - a free-running cycle counter.
- Sits beside the single-cycle core at top level. Reads must be same-cycle; writes commit on the clock edge.

Parameters:
- `RAM_WORDS`, 256, number of 32-bit data RAM words (power of two).
- `FIFO_DEPTH`, 8, transmit FIFO entries (power of two, >= 2).
- `MMIO_BASE`, 32'hFFFF_FF00, base of the 256-byte MMIO window (`a[31:8]` match).

Ports:
- `clk`, input, 1, rising-edge clock.
- `reset`, input, 1, synchronous, active-high reset.
- `we`, input, 1, write strobe (core `memwrite`).
- `a`, input, 32, byte address (core `aluout`).
- `wd`, input, 32, write data (core `writedata`).
- `rd`, output, 32, read data (core `readdata`), combinational from `a`.
- `tx_data`, output, 8, FIFO head byte.
- `tx_valid`, output, 1, FIFO non-empty.
- `tx_ready`, input, 1, consumer accepts head this cycle.

Behaviour:
- **Decode:**
  - MMIO hit when `a[31:8] == MMIO_BASE[31:8]`; otherwise RAM.
  - RAM index = `a[log2(RAM_WORDS)+1:2]`; upper bits ignored (aliasing); `a[1:0]` ignored everywhere.
- **RAM:**
  - `rd` = `mem[index]` combinationally.
  - On posedge with `we` and RAM hit, `mem[index] <= wd`.
  - Contents are not reset.
  - Read-during-write of the same word returns old data in that cycle, new data afterward.
- **MMIO offsets (`a[7:0]`):**
  - `0x00` TXDATA:
    - Write pushes `wd[7:0]`; read returns 0.
    - Push while full and no pop in the same cycle: byte dropped, `ovf` sticky set.
  - `0x04` STATUS:
    - Read returns {`count` in bits [log2(FIFO_DEPTH)+3:3], `ovf` bit2, `full` bit1, `empty` bit0}, zero elsewhere.
    - Write with `wd[2]=1` clears `ovf`; other bits are read-only.
  - `0x08` CYCLE:
    - Read returns the current counter value.
    - Write loads `wd`: the counter equals `wd` the next cycle, then increments.
  - Any other offset: read 0, write ignored.
- **Cycle counter:** increments by 1 every cycle not reset or loaded; wraps `FFFF_FFFF` -> 0.
- **FIFO:**
  - Circular buffer with read/write pointers and `count` of width log2(FIFO_DEPTH)+1.
  - `tx_valid = (count != 0)`; `tx_data` = head entry (0 when empty is acceptable; the bench checks only while valid).
  - Pop when `tx_valid && tx_ready`.
  - Push and pop in the same cycle:
    - when non-empty: both happen, `count` unchanged;
    - when full: push accepted, no overflow;
    - when empty: push only (no fall-through; data is visible the next cycle).
  - Pointers wrap modulo FIFO_DEPTH.
- **Reset (sync, on posedge with `reset=1`):**
  - FIFO emptied, `count=0`, `tx_valid=0`, `ovf=0`, cycle counter `=0`.
  - Writes presented in a reset cycle are ignored for MMIO state; RAM writes still commit.
  - Reset in the middle of a drain discards all queued bytes.
- **Latency:**
  - All register reads are combinational.
  - All state updates take effect one clock after the edge that samples them.

Test Plan:
- **RAM access:** write `32'hDEADBEEF` to `0x40`, read `0x40` and `0x43` -> both `DEADBEEF`; read `0x40 + 4*RAM_WORDS` -> `DEADBEEF` (alias).
- **FIFO order:** with `tx_ready=0`, push `0x11,0x22,0x33`:
  - STATUS reads `count=3`, `empty=0`, `full=0`;
  - raise `tx_ready` -> `tx_data` sequence `11,22,33`, then `tx_valid=0`, STATUS `empty=1`.
- **Overflow:** with `tx_ready=0`, push 9 bytes (depth 8):
  - 9th dropped; STATUS `full=1`, `ovf=1`, `count=8`;
  - write STATUS `wd=4` -> `ovf=0`, `full` still 1.
- **Push/pop when full:** full FIFO, `tx_ready=1` and push `0xAA` in the same cycle -> `ovf` stays 0, `count` stays 8, `0xAA` emerges last.
- **Cycle counter:**
  - after reset, read CYCLE N cycles later -> N;
  - write `FFFF_FFFE` -> reads `FFFF_FFFE`, `FFFF_FFFF`, `0` on successive cycles.
- **Mid-drain reset:** 4 bytes queued, assert `reset` for one cycle mid-drain -> `tx_valid=0`, STATUS = 1 (empty only), CYCLE = 0 the following cycle; RAM contents unchanged.
